// File: rtl/picomips_pkg.sv
// Shared picoMips definitions: instruction field widths, opcode values and
// the fetch-unit state type.
package picomips_pkg;

  localparam int INSTR_W  = 12;
  localparam int OPCODE_W = 6;
  localparam int IMM_W    = 6;

  localparam logic [OPCODE_W-1:0] OP_NOP  = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_ADD  = 6'b000001;
  localparam logic [OPCODE_W-1:0] OP_ADDI = 6'b000010;
  localparam logic [OPCODE_W-1:0] OP_SUB  = 6'b000011;
  localparam logic [OPCODE_W-1:0] OP_MUL  = 6'b000100;
  localparam logic [OPCODE_W-1:0] OP_LS   = 6'b000101;
  localparam logic [OPCODE_W-1:0] OP_BEQ  = 6'b000110;
  localparam logic [OPCODE_W-1:0] OP_HEI  = 6'b001000;

  typedef enum logic [1:0] {
    FILL = 2'b00,
    RUN  = 2'b01,
    WAIT = 2'b10
  } fetch_state_t;

  // Opcode field of an instruction word.
  function automatic logic [OPCODE_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[INSTR_W-1 -: OPCODE_W];
  endfunction

endpackage

// File: rtl/fetch_unit_sw_debounce.sv
// Switch conditioner: SYNC_STG-flop synchroniser followed by a debouncer that
// accepts a new level only after it has been stable for DEB_CYC cycles.
module sw_debounce #(
  parameter int SYNC_STG = 2,
  parameter int DEB_CYC  = 4
) (
  input  logic Clock,
  input  logic Reset,
  input  logic in,
  output logic out
);

  localparam int CNT_W = $clog2(DEB_CYC + 1);

  logic [SYNC_STG-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                db_q, db_d;
  logic                s;

  // Shift the raw input through the synchroniser and run the stability counter.
  always_comb begin
    sync_d = {sync_q[SYNC_STG-2:0], in};
    s      = sync_q[SYNC_STG-1];
    db_d   = db_q;
    cnt_d  = '0;
    if (s != db_q) begin
      if (cnt_q == CNT_W'(DEB_CYC - 1)) begin
        db_d  = s;
        cnt_d = '0;
      end else if (cnt_q != '1) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        cnt_d = cnt_q;
      end
    end
  end

  // Synchroniser, counter and accepted level registers.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      sync_q <= '0;
      cnt_q  <= '0;
      db_q   <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      db_q   <= db_d;
    end
  end

  assign out = db_q;

endmodule

// File: rtl/fetch_unit.sv
// picoMips fetch unit: program counter with wrap, FILL/RUN/WAIT control for
// the 1-cycle registered program memory, and the HEI wait on debounced SW8.
module fetch_unit
  import picomips_pkg::*;
#(
  parameter int ADDR_W   = 5,
  parameter int PROG_LEN = 24,
  parameter int SYNC_STG = 2,
  parameter int DEB_CYC  = 4
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               SW8,
  input  logic [INSTR_W-1:0] Instruction,
  output logic [ADDR_W-1:0]  Addr,
  output logic               Valid,
  output logic               Stall,
  output logic               SW8_db
);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              wait_lvl_q, wait_lvl_d;
  logic              valid_q, valid_d;
  logic              stall_q, stall_d;

  logic              sw8_db;
  logic [ADDR_W-1:0] pc_inc;
  logic              hei_lvl;
  logic              hei_block;
  logic              unused_imm_bits;

  sw_debounce #(
    .SYNC_STG (SYNC_STG),
    .DEB_CYC  (DEB_CYC)
  ) u_sw8_debounce (
    .Clock (Clock),
    .Reset (Reset),
    .in    (SW8),
    .out   (sw8_db)
  );

  // Next-state, PC and registered-output logic. Valid/Stall are computed from
  // the next state so they line up with the registered state.
  always_comb begin
    pc_inc          = (pc_q == ADDR_W'(PROG_LEN - 1)) ? '0 : pc_q + ADDR_W'(1);
    hei_lvl         = Instruction[0];
    unused_imm_bits = ^Instruction[IMM_W-1:1];
    hei_block       = (opcode_of(Instruction) == OP_HEI) && (sw8_db == hei_lvl);

    state_d    = state_q;
    pc_d       = pc_q;
    wait_lvl_d = wait_lvl_q;
    valid_d    = 1'b0;
    stall_d    = 1'b0;

    case (state_q)
      FILL: begin
        pc_d    = pc_inc;
        state_d = RUN;
        valid_d = 1'b1;
      end
      RUN: begin
        if (hei_block) begin
          wait_lvl_d = hei_lvl;
          state_d    = WAIT;
          stall_d    = 1'b1;
        end else begin
          pc_d    = pc_inc;
          valid_d = 1'b1;
        end
      end
      WAIT: begin
        if (sw8_db != wait_lvl_q) begin
          pc_d    = pc_inc;
          state_d = RUN;
          valid_d = 1'b1;
        end else begin
          stall_d = 1'b1;
        end
      end
      default: begin
        state_d = FILL;
        pc_d    = '0;
      end
    endcase
  end

  // State, PC and output registers.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q    <= FILL;
      pc_q       <= '0;
      wait_lvl_q <= 1'b0;
      valid_q    <= 1'b0;
      stall_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      wait_lvl_q <= wait_lvl_d;
      valid_q    <= valid_d;
      stall_q    <= stall_d;
    end
  end

  assign Addr   = pc_q;
  assign Valid  = valid_q;
  assign Stall  = stall_q;
  assign SW8_db = sw8_db;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: the stimulus process runs an instruction-level
// reference model and queues the expected outputs for every cycle; a monitor
// pops and compares them on the falling edge.
module tb_fetch_unit;
  import picomips_pkg::*;

  localparam int AW   = 5;
  localparam int L    = 24;
  localparam int SYNC = 2;
  localparam int DEB  = 4;

  typedef struct {
    logic          valid;
    logic          stall;
    logic [AW-1:0] addr;
    logic          db;
  } exp_t;

  logic               clk = 1'b0;
  logic               Reset = 1'b1;
  logic               SW8 = 1'b0;
  logic [INSTR_W-1:0] Instruction = '0;
  logic [AW-1:0]      Addr;
  logic               Valid;
  logic               Stall;
  logic               SW8_db;

  logic [INSTR_W-1:0] prog [32];
  exp_t               exp_q[$];
  logic               sw_plan[$];
  logic               raw_s[$];
  logic               mon_en = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic    m_run;
  int      m_a;
  logic    m_lvl;
  logic    m_db;

  fetch_unit #(
    .ADDR_W   (AW),
    .PROG_LEN (L),
    .SYNC_STG (SYNC),
    .DEB_CYC  (DEB)
  ) dut (
    .Clock       (clk),
    .Reset       (Reset),
    .SW8         (SW8),
    .Instruction (Instruction),
    .Addr        (Addr),
    .Valid       (Valid),
    .Stall       (Stall),
    .SW8_db      (SW8_db)
  );

  always #5 clk = ~clk;

  // program memory with a registered 1-cycle read
  always @(posedge clk) Instruction <= prog[Addr];

  task automatic chk(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
    end
  endtask

  // monitor: one expected record per cycle
  initial begin
    exp_t e;
    int   idx;
    forever begin
      @(negedge clk);
      if (mon_en && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("valid", int'(Valid), int'(e.valid));
        chk("stall", int'(Stall), int'(e.stall));
        chk("addr", int'(Addr), int'(e.addr));
        chk("sw8_db", int'(SW8_db), int'(e.db));
        if (e.valid) begin
          idx = (int'(e.addr) + L - 1) % L;
          chk("instr", int'(Instruction), int'(prog[idx]));
        end
      end
    end
  end

  task automatic plan(input logic v, input int len);
    for (int i = 0; i < len; i++) sw_plan.push_back(v);
  endtask

  task automatic prog_nop();
    for (int i = 0; i < 32; i++) prog[i] = {OP_NOP, 6'd0};
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_addr"}, int'(Addr), 0);
    chk({tag, "_valid"}, int'(Valid), 0);
    chk({tag, "_stall"}, int'(Stall), 0);
    chk({tag, "_sw8db"}, int'(SW8_db), 0);
  endtask

  // One run from reset release; rst_at>0 asserts Reset mid-run after that many edges.
  task automatic run_seg(input string tag, input int rst_at);
    logic [INSTR_W-1:0] ins;
    mon_en = 1'b0;
    Reset  = 1'b1;
    SW8    = 1'b0;
    #1;
    chk_reset_outputs({tag, "_rst"});
    exp_q.delete();
    raw_s.delete();
    m_run = 1'b1;
    m_a   = 0;
    m_lvl = 1'b0;
    m_db  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    Reset  = 1'b0;
    mon_en = 1'b1;
    exp_q.push_back('{1'b0, 1'b0, '0, 1'b0});
    for (int n = 0; n < sw_plan.size(); n++) begin
      SW8 = sw_plan[n];
      raw_s.push_back(sw_plan[n]);
      // accepted level: the DEB most recent samples past the synchroniser agree
      if (n >= SYNC + DEB - 1) begin
        int   lo;
        logic same;
        lo   = n - SYNC - DEB + 1;
        same = 1'b1;
        for (int k = lo; k <= n - SYNC; k++)
          if (raw_s[k] != raw_s[lo]) same = 1'b0;
        if (same) m_db = raw_s[lo];
      end
      if (m_run) begin
        exp_q.push_back('{1'b1, 1'b0, AW'((m_a + 1) % L), m_db});
        ins = prog[m_a];
        if (ins[INSTR_W-1 -: OPCODE_W] == OP_HEI && m_db == ins[0]) begin
          m_run = 1'b0;
          m_lvl = ins[0];
        end else begin
          m_a = (m_a + 1) % L;
        end
      end else begin
        exp_q.push_back('{1'b0, 1'b1, AW'((m_a + 1) % L), m_db});
        if (m_db != m_lvl) begin
          m_run = 1'b1;
          m_a   = (m_a + 1) % L;
        end
      end
      @(posedge clk);
      #1;
      if (n + 1 == rst_at) begin
        #2;
        mon_en = 1'b0;
        Reset  = 1'b1;
        #1;
        chk_reset_outputs({tag, "_midrst"});
        exp_q.delete();
        sw_plan.delete();
        return;
      end
    end
    @(negedge clk);
    #1;
    chk({tag, "_drain"}, exp_q.size(), 0);
    mon_en = 1'b0;
    sw_plan.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    // NOP stream with a non-blocking HEI 1 and an HEI 0 at the last address
    prog_nop();
    prog[5]  = {OP_HEI, 6'b000001};
    prog[23] = {OP_HEI, 6'b111110};
    plan(1'b0, 40); plan(1'b1, 20); plan(1'b0, 15);
    run_seg("wrap", 0);

    // HEI 0 at address 0, a 3-cycle glitch, then a real release
    prog_nop();
    prog[0] = {OP_HEI, 6'b000000};
    prog[7] = {OP_LS, 6'b010101};
    plan(1'b0, 10); plan(1'b1, 3); plan(1'b0, 8); plan(1'b1, 15);
    run_seg("glitch", 0);

    // reset while waiting with the debounce counter part-way
    plan(1'b0, 6); plan(1'b1, 20);
    run_seg("rstwait", 10);

    // restart after the mid-wait reset with SW8 already high
    plan(1'b1, 30);
    run_seg("restart", 0);

    // random program and switch activity
    for (int i = 0; i < L; i++) begin
      if ($urandom_range(3) == 0) prog[i] = {OP_HEI, 6'($urandom)};
      else                        prog[i] = {6'($urandom_range(6)), 6'($urandom)};
    end
    while (sw_plan.size() < 400) plan(1'($urandom_range(1)), int'($urandom_range(1, 12)));
    run_seg("random", 0);

    // random run cut by a reset
    while (sw_plan.size() < 120) plan(1'($urandom_range(1)), int'($urandom_range(1, 12)));
    run_seg("randrst", 77);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
